// File: rtl/cnt_stamp_fifo.sv
// Timestamp capture FIFO: extends an upstream counter with a wrap count and queues stamps on trigger.
// Optional macro CNT_STAMP_DROP_CNT_EN adds a saturating drop_cnt output.
module cnt_stamp_fifo #(
  parameter int CNT_W  = 8,
  parameter int WRAP_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          cnt_in,
  input  logic                      trig,
  input  logic                      rd_ready,
  input  logic                      ovf_clr,
  output logic                      rd_valid,
  output logic [WRAP_W+CNT_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      overflow
`ifdef CNT_STAMP_DROP_CNT_EN
  ,
  output logic [7:0]                drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = WRAP_W + CNT_W;

  logic [CNT_W-1:0]  prev_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WRAP_W-1:0] wrap_cnt_next;
  logic              wrap;
  logic [DW-1:0]     stamp;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_inc;
  logic [PW-1:0]     wr_ptr;
  logic [DW-1:0]     mem [DEPTH];
  logic [LW-1:0]     level_next;
  logic              pop;
  logic              push;
  logic              drop;

  // Only an all-ones to zero step is a wrap; any other return to zero is an upstream reset.
  always_comb begin
    wrap          = (prev_cnt == '1) && (cnt_in == '0);
    wrap_cnt_next = wrap_cnt + WRAP_W'(wrap);
    stamp         = {wrap_cnt_next, cnt_in};
    pop           = rd_valid && rd_ready;
    push          = trig && (!full || pop);
    drop          = trig && full && !pop;
    rd_ptr_inc    = rd_ptr + PW'(1);
    level_next    = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt <= '0;
      wrap_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      prev_cnt <= cnt_in;
      wrap_cnt <= wrap_cnt_next;
      level    <= level_next;
      rd_valid <= (level_next != '0);
      full     <= (level_next == LW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      // The head register must track the slot that becomes the head after this edge.
      if (pop && level != LW'(1))
        rd_data <= mem[rd_ptr_inc];
      else if (push && (level == '0 || pop))
        rd_data <= stamp;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= stamp;
  end

`ifdef CNT_STAMP_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= 8'd0;
    else if (ovf_clr)
      drop_cnt <= drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cnt_stamp_fifo.sv
// Self-checking bench for cnt_stamp_fifo: scoreboard monitor plus per-scenario directed checks.
module tb_cnt_stamp_fifo;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    cnt_in = 8'h00;
  logic          trig = 1'b0;
  logic          rd_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [LW-1:0] level;
  logic          full;
  logic          overflow;
`ifdef CNT_STAMP_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cnt_stamp_fifo #(.CNT_W(8), .WRAP_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .trig(trig), .rd_ready(rd_ready),
    .ovf_clr(ovf_clr), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .full(full), .overflow(overflow)
`ifdef CNT_STAMP_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: stamps are queued as triggers are driven and compared as the reader pops.
  logic [DW-1:0] exp_q[$];
  logic [7:0]    m_prev = 8'h00;
  logic [7:0]    m_wrap = 8'h00;
  logic          m_ovf  = 1'b0;
  logic [7:0]    m_drop = 8'h00;
  bit            armed  = 1'b0;

  always @(negedge clk) begin
    logic [7:0]    w_next;
    logic [DW-1:0] st;
    bit            m_full;
    bit            m_pop;
    if (armed) begin
      checks++;
      if (rd_valid !== (exp_q.size() != 0)) begin
        errors++; $display("[TB] FAIL mon_rd_valid got %b want %b", rd_valid, exp_q.size() != 0);
      end
      checks++;
      if (level !== LW'(exp_q.size())) begin
        errors++; $display("[TB] FAIL mon_level got %0d want %0d", level, exp_q.size());
      end
      checks++;
      if (full !== (exp_q.size() == DEPTH)) begin
        errors++; $display("[TB] FAIL mon_full got %b want %b", full, exp_q.size() == DEPTH);
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++; $display("[TB] FAIL mon_overflow got %b want %b", overflow, m_ovf);
      end
`ifdef CNT_STAMP_DROP_CNT_EN
      checks++;
      if (drop_cnt !== m_drop) begin
        errors++; $display("[TB] FAIL mon_drop_cnt got %0d want %0d", drop_cnt, m_drop);
      end
`endif
    end
    if (rst) begin
      exp_q.delete();
      m_prev = 8'h00; m_wrap = 8'h00; m_ovf = 1'b0; m_drop = 8'h00;
      armed = 1'b1;
    end else if (armed) begin
      w_next = m_wrap + ((m_prev == 8'hFF && cnt_in == 8'h00) ? 8'd1 : 8'd0);
      st     = {w_next, cnt_in};
      m_full = (exp_q.size() == DEPTH);
      m_pop  = (exp_q.size() != 0) && rd_ready;
      if (m_pop) begin
        checks++;
        if (rd_data !== exp_q[0]) begin
          errors++; $display("[TB] FAIL mon_pop_data got %h want %h", rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (trig && (!m_full || m_pop)) exp_q.push_back(st);
      if (ovf_clr) begin m_ovf = 1'b0; m_drop = 8'h00; end
      if (trig && m_full && !m_pop) begin
        m_ovf = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
      m_prev = cnt_in;
      m_wrap = w_next;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; trig = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0; cnt_in = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; trig = 1'b1; cnt_in = 8'h00;
    repeat (3) tick();
    rst = 1'b0; trig = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++;
    if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", level); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", full); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    checks++;
    if (rd_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rd_data got %h want 0000", rd_data); end
  endtask

  task automatic test_single_capture();
    cnt_in = 8'h05; trig = 1'b1;
    tick();
    trig = 1'b0;
    checks++;
    if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", rd_valid); end
    checks++;
    if (rd_data !== 16'h0005) begin errors++; $display("[TB] FAIL single_data got %h want 0005", rd_data); end
    checks++;
    if (level !== 3'd1) begin errors++; $display("[TB] FAIL single_level got %0d want 1", level); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || level !== 3'd0) begin
      errors++; $display("[TB] FAIL single_drain got valid=%b level=%0d want valid=0 level=0", rd_valid, level);
    end
  endtask

  task automatic test_wrap_vs_reset();
    do_reset();
    cnt_in = 8'hFE; tick();
    cnt_in = 8'hFF; tick();
    cnt_in = 8'h00; trig = 1'b1; tick();
    trig = 1'b0;
    checks++;
    if (rd_data !== 16'h0100) begin errors++; $display("[TB] FAIL wrap_stamp got %h want 0100", rd_data); end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    cnt_in = 8'h37; tick();
    cnt_in = 8'h00; trig = 1'b1; tick();
    trig = 1'b0;
    checks++;
    if (rd_data !== 16'h0100) begin errors++; $display("[TB] FAIL upstream_reset_stamp got %h want 0100", rd_data); end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    do_reset();
    for (int v = 0; v <= 270; v++) begin
      cnt_in = v[7:0];
      trig = (v == 270);
      tick();
    end
    trig = 1'b0;
    checks++;
    if (rd_data !== 16'h010E) begin errors++; $display("[TB] FAIL long_count_stamp got %h want 010E", rd_data); end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cnt_in = 8'h0A + 8'(i); trig = 1'b1;
      tick();
      if (i == 3) begin
        checks++;
        if (full !== 1'b1 || level !== 3'd4) begin
          errors++; $display("[TB] FAIL fill_full got full=%b level=%0d want full=1 level=4", full, level);
        end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_early_ovf got %b want 0", overflow); end
      end
    end
    trig = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL drop_overflow got %b want 1", overflow); end
    checks++;
    if (level !== 3'd4) begin errors++; $display("[TB] FAIL drop_level got %0d want 4", level); end
`ifdef CNT_STAMP_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL drop_cnt got %0d want 1", drop_cnt); end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data !== 16'h000A + 16'(i)) begin
        errors++; $display("[TB] FAIL drain_order got %h want %h", rd_data, 16'h000A + 16'(i));
      end
      rd_ready = 1'b1; tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (level !== 3'd0 || overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL drain_end got level=%0d ovf=%b want level=0 ovf=1", level, overflow);
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clr got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cnt_in = 8'h30; trig = 1'b1; tick();
    cnt_in = 8'h31; rd_ready = 1'b1; tick();
    rd_ready = 1'b0;
    checks++;
    if (level !== 3'd1 || rd_data !== 16'h0031) begin
      errors++; $display("[TB] FAIL pushpop_lvl1 got level=%0d data=%h want level=1 data=0031", level, rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      cnt_in = 8'h32 + 8'(i); tick();
    end
    cnt_in = 8'h35; rd_ready = 1'b1; tick();
    rd_ready = 1'b0;
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || rd_data !== 16'h0032) begin
      errors++; $display("[TB] FAIL pushpop_full got level=%0d ovf=%b data=%h want level=4 ovf=0 data=0032",
                         level, overflow, rd_data);
    end
    cnt_in = 8'h36; ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0; trig = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL clr_vs_drop got %b want 1", overflow); end
`ifdef CNT_STAMP_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL clr_vs_drop_cnt got %0d want 1", drop_cnt); end
`endif
    rd_ready = 1'b1; repeat (4) tick(); rd_ready = 1'b0;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cnt_in = 8'hFF; tick();
    cnt_in = 8'h00; tick();
    cnt_in = 8'hFF; tick();
    cnt_in = 8'h00; tick();
    for (int i = 0; i < 3; i++) begin
      cnt_in = 8'h10 + 8'(i); trig = 1'b1; tick();
    end
    trig = 1'b0;
    checks++;
    if (level !== 3'd3 || rd_data !== 16'h0210) begin
      errors++; $display("[TB] FAIL mid_setup got level=%0d data=%h want level=3 data=0210", level, rd_data);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (level !== 3'd0 || rd_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset got level=%0d valid=%b want level=0 valid=0", level, rd_valid);
    end
    cnt_in = 8'h01; trig = 1'b1; tick();
    trig = 1'b0;
    checks++;
    if (rd_data !== 16'h0001) begin errors++; $display("[TB] FAIL mid_after_stamp got %h want 0001", rd_data); end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_wrap_vs_reset();
    test_fill_overflow();
    test_back_to_back();
    test_reset_mid();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL final_queue got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
